pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Parametrised pipeline stall/flush controller for the MIPS datapath, driving per-stage hold enables for N pipeline registers (PC through MEM_WB). It arbitrates load-use hazards (bubble insertion) against cache-miss freezes. It also holds branch/jump flushes pending across a freeze. It adds saturating stall-statistics counters and a sticky miss-timeout flag for bench/debug visibility.

Parameters:
NSTAGE, 5, number of stall enables; bit 0 = PC, bit NSTAGE-1 = last pipeline register; legal >= 3
HAZ_STAGE, 2, number of leading stages held on a load-use hazard; legal 1..NSTAGE-1
CNT_W, 16, width of each statistics counter
MISS_TIMEOUT, 64, consecutive FREEZE cycles that set memTimeout; legal >= 2

Ports:
Clk  in  1  system clock; all state updates on falling edge
Rst  in  1  asynchronous, active-high reset
hazard  in  1  load-use hazard detected in ID
branch  in  1  taken branch resolved
jump  in  1  jump decoded
imemError  in  1  instruction cache miss
dmemError  in  1  data cache miss
MEM_memRead  in  1  MEM-stage load
MEM_memWrite  in  1  MEM-stage store
clrCnt  in  1  synchronous clear of statistics counters
stall  out  NSTAGE  per-stage hold (1 = hold register)
nop  out  1  deassert ID_EX controls (bubble)
flush  out  1  flush IF_ID
state  out  2  current FSM state (debug)
bubbleCnt  out  CNT_W  cycles spent in BUBBLE
freezeCnt  out  CNT_W  cycles spent in FREEZE
flushCnt  out  CNT_W  cycles with flush asserted
memTimeout  out  1  sticky: freeze exceeded MISS_TIMEOUT

Behaviour:
- Reset (async, posedge Rst): state = NORMAL, flushPend = 0, missRun = 0, all counters = 0, memTimeout = 0. Outputs therefore reset to stall = 0, nop = 0, flush = branch|jump.
- memHaz = (dmemError & (MEM_memRead | MEM_memWrite)) | imemError.
- FSM states: NORMAL=2'b00, BUBBLE=2'b01, FREEZE=2'b10; 2'b11 is illegal and decodes as NORMAL, with next edge -> normal evaluation.
- Next state is sampled on every negedge Clk, independent of the current state. memHaz -> FREEZE. Else hazard -> BUBBLE. Else NORMAL. memHaz has priority over hazard.
- Outputs are combinational from state only (Moore), so they are stable for the following posedge.
- Output decode by state:
  - NORMAL: stall = 0, nop = 0.
  - BUBBLE: stall[HAZ_STAGE-1:0] = 1, remaining bits = 0, nop = 1.
  - FREEZE: stall = all ones, nop = 0.
- Flush:
  - flush = (branch | jump | flushPend) & (state != FREEZE).
  - At negedge, if state == FREEZE and (branch | jump), set flushPend. If state != FREEZE, clear flushPend.
  - Net effect: a pending flush is delivered on exactly the first non-FREEZE cycle.
  - Flush during BUBBLE is allowed. flush and nop may both be 1.
- missRun, width $clog2(MISS_TIMEOUT)+1:
  - Increments each negedge while state == FREEZE; resets to 0 otherwise.
  - Saturates at MISS_TIMEOUT.
  - When missRun reaches MISS_TIMEOUT, memTimeout sets to 1. Only Rst clears it.
- Counters, updated on negedge:
  - bubbleCnt increments when state == BUBBLE.
  - freezeCnt increments when state == FREEZE.
  - flushCnt increments when flush == 1.
  - All saturate at 2^CNT_W-1; no wrap.
  - clrCnt = 1 zeroes all three on that edge, taking priority over increment. clrCnt does not affect memTimeout.
- Rst asserted mid-freeze: immediate return to NORMAL. A pending flush is discarded.

Test Plan:
1. Rst pulse, no inputs, 10 cycles -> stall = 5'b00000, nop = 0, flush = 0, all counters 0, state = 00 throughout.
2. hazard = 1 for one cycle (defaults) -> after next negedge: stall = 5'b00011, nop = 1 for one cycle, then 5'b00000; bubbleCnt = 1.
3. dmemError = 1 with MEM_memRead = 1 and hazard = 1 held 3 cycles -> stall = 5'b11111, nop = 0 for 3 cycles (freeze wins); freezeCnt = 3, bubbleCnt = 0. Repeat with MEM_memRead = MEM_memWrite = 0 -> BUBBLE instead.
4. branch = 1 for one cycle during a 4-cycle imemError freeze -> flush = 0 while frozen; flush = 1 on exactly the first NORMAL cycle, then 0; flushCnt = 1.
5. MISS_TIMEOUT = 4, imemError held 6 cycles -> memTimeout rises after 4th FREEZE negedge and stays 1 after imemError drops; clrCnt leaves it 1; Rst clears it.
6. CNT_W = 3, hazard held 10 cycles -> bubbleCnt saturates at 7; clrCnt pulse -> 0. Separately, Rst asserted mid-freeze with flushPend set -> state = 00 immediately and no flush afterwards.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller.
// Drives per-stage holds, bubble and flush controls.
//
// Ports:
//   Clk, Rst        clock (state moves on falling edge), async active-high reset
//   hazard          load-use hazard seen in ID
//   branch, jump    taken branch / jump; request an IF_ID flush
//   imemError       instruction cache miss
//   dmemError       data cache miss (counts only with a MEM-stage access)
//   MEM_memRead/Wr  MEM-stage load / store
//   clrCnt          synchronous clear of the statistics counters
//   stall           per-stage hold, bit 0 = PC
//   nop             bubble into ID_EX
//   flush           flush IF_ID
//   state           FSM state (debug)
//   bubbleCnt, freezeCnt, flushCnt  saturating statistics
//   memTimeout      sticky flag: freeze ran for MISS_TIMEOUT cycles
module pipe_stall_ctrl #(
    parameter int NSTAGE       = 5,
    parameter int HAZ_STAGE    = 2,
    parameter int CNT_W        = 16,
    parameter int MISS_TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              hazard,
    input  logic              branch,
    input  logic              jump,
    input  logic              imemError,
    input  logic              dmemError,
    input  logic              MEM_memRead,
    input  logic              MEM_memWrite,
    input  logic              clrCnt,
    output logic [NSTAGE-1:0] stall,
    output logic              nop,
    output logic              flush,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  bubbleCnt,
    output logic [CNT_W-1:0]  freezeCnt,
    output logic [CNT_W-1:0]  flushCnt,
    output logic              memTimeout
);

    localparam int MR_W = $clog2(MISS_TIMEOUT) + 1;
    localparam logic [MR_W-1:0] MR_MAX = MR_W'(MISS_TIMEOUT);
    localparam logic [NSTAGE-1:0] HAZ_MASK =
        (NSTAGE'(1) << HAZ_STAGE) - NSTAGE'(1);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BUBBLE = 2'b01,
        FREEZE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             flushPend_q, flushPend_d;
    logic [MR_W-1:0]  missRun_q, missRun_d;
    logic             memTimeout_q, memTimeout_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0] freezeCnt_q, freezeCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic mem_haz;
    logic frozen;
    logic bubbling;
    logic flush_c;

    assign mem_haz = (dmemError & (MEM_memRead | MEM_memWrite)) | imemError;

    // 2'b11 is not FREEZE or BUBBLE, so it behaves as NORMAL
    assign frozen   = (state_q == FREEZE);
    assign bubbling = (state_q == BUBBLE);

    // A flush seen while frozen is parked and delivered on the first
    // non-frozen cycle.
    assign flush_c = (branch | jump | flushPend_q) & ~frozen;

    always_comb begin
        stall = '0;
        nop   = 1'b0;
        if (frozen) begin
            stall = '1;
        end else if (bubbling) begin
            stall = HAZ_MASK;
            nop   = 1'b1;
        end
    end

    always_comb begin
        state_d      = NORMAL;
        flushPend_d  = 1'b0;
        missRun_d    = '0;
        memTimeout_d = memTimeout_q;
        bubbleCnt_d  = bubbleCnt_q;
        freezeCnt_d  = freezeCnt_q;
        flushCnt_d   = flushCnt_q;

        if (mem_haz) begin
            state_d = FREEZE;
        end else if (hazard) begin
            state_d = BUBBLE;
        end

        if (frozen) begin
            flushPend_d = flushPend_q | branch | jump;
            missRun_d   = (missRun_q == MR_MAX) ? missRun_q
                                                : missRun_q + 1'b1;
        end

        if (missRun_d == MR_MAX) begin
            memTimeout_d = 1'b1;
        end

        if (clrCnt) begin
            bubbleCnt_d = '0;
            freezeCnt_d = '0;
            flushCnt_d  = '0;
        end else begin
            if (bubbling && bubbleCnt_q != '1) begin
                bubbleCnt_d = bubbleCnt_q + 1'b1;
            end
            if (frozen && freezeCnt_q != '1) begin
                freezeCnt_d = freezeCnt_q + 1'b1;
            end
            if (flush_c && flushCnt_q != '1) begin
                flushCnt_d = flushCnt_q + 1'b1;
            end
        end
    end

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= NORMAL;
            flushPend_q  <= 1'b0;
            missRun_q    <= '0;
            memTimeout_q <= 1'b0;
            bubbleCnt_q  <= '0;
            freezeCnt_q  <= '0;
            flushCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flushPend_q  <= flushPend_d;
            missRun_q    <= missRun_d;
            memTimeout_q <= memTimeout_d;
            bubbleCnt_q  <= bubbleCnt_d;
            freezeCnt_q  <= freezeCnt_d;
            flushCnt_q   <= flushCnt_d;
        end
    end

    assign flush      = flush_c;
    assign state      = state_q;
    assign bubbleCnt  = bubbleCnt_q;
    assign freezeCnt  = freezeCnt_q;
    assign flushCnt   = flushCnt_q;
    assign memTimeout = memTimeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl.
// Small CNT_W / MISS_TIMEOUT so saturation and timeout are reachable.
module tb_pipe_stall_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       hazard = 1'b0;
    logic       branch = 1'b0;
    logic       jump = 1'b0;
    logic       imemError = 1'b0;
    logic       dmemError = 1'b0;
    logic       MEM_memRead = 1'b0;
    logic       MEM_memWrite = 1'b0;
    logic       clrCnt = 1'b0;
    logic [4:0] stall;
    logic       nop;
    logic       flush;
    logic [1:0] state;
    logic [2:0] bubbleCnt;
    logic [2:0] freezeCnt;
    logic [2:0] flushCnt;
    logic       memTimeout;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(
        .NSTAGE(5),
        .HAZ_STAGE(2),
        .CNT_W(3),
        .MISS_TIMEOUT(4)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .hazard(hazard),
        .branch(branch),
        .jump(jump),
        .imemError(imemError),
        .dmemError(dmemError),
        .MEM_memRead(MEM_memRead),
        .MEM_memWrite(MEM_memWrite),
        .clrCnt(clrCnt),
        .stall(stall),
        .nop(nop),
        .flush(flush),
        .state(state),
        .bubbleCnt(bubbleCnt),
        .freezeCnt(freezeCnt),
        .flushCnt(flushCnt),
        .memTimeout(memTimeout)
    );

    always #5 Clk = ~Clk;

    // one full cycle: passes a negedge (state update), lands 1 after posedge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        hazard = 0; branch = 0; jump = 0; imemError = 0;
        dmemError = 0; MEM_memRead = 0; MEM_memWrite = 0; clrCnt = 0;
        Rst = 1;
        #2;
        Rst = 0;
    endtask

    task automatic clear_cnt();
        clrCnt = 1;
        cyc();
        clrCnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (stall !== 5'b00000 || nop !== 1'b0 || flush !== 1'b0 ||
                state !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: stall=%b nop=%b flush=%b state=%b want 00000 0 0 00",
                         i, stall, nop, flush, state);
            end
        end
        checks++;
        if (bubbleCnt !== 3'd0 || freezeCnt !== 3'd0 || flushCnt !== 3'd0 ||
            memTimeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: b=%0d f=%0d fl=%0d to=%b want 0 0 0 0",
                     bubbleCnt, freezeCnt, flushCnt, memTimeout);
        end
    endtask

    task automatic test_bubble();
        hazard = 1;
        cyc();
        hazard = 0;
        checks++;
        if (stall !== 5'b00011 || nop !== 1'b1 || state !== 2'b01) begin
            errors++;
            $display("FAIL bubble_on: stall=%b nop=%b state=%b want 00011 1 01",
                     stall, nop, state);
        end
        cyc();
        checks++;
        if (stall !== 5'b00000 || nop !== 1'b0 || bubbleCnt !== 3'd1) begin
            errors++;
            $display("FAIL bubble_off: stall=%b nop=%b bcnt=%0d want 00000 0 1",
                     stall, nop, bubbleCnt);
        end
    endtask

    task automatic test_priority();
        clear_cnt();
        dmemError = 1; MEM_memRead = 1; hazard = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (stall !== 5'b11111 || nop !== 1'b0 || state !== 2'b10) begin
                errors++;
                $display("FAIL freeze_wins cyc%0d: stall=%b nop=%b state=%b want 11111 0 10",
                         i, stall, nop, state);
            end
        end
        dmemError = 0; MEM_memRead = 0; hazard = 0;
        cyc();
        checks++;
        if (freezeCnt !== 3'd3 || bubbleCnt !== 3'd0 || memTimeout !== 1'b0) begin
            errors++;
            $display("FAIL freeze_cnt: f=%0d b=%0d to=%b want 3 0 0",
                     freezeCnt, bubbleCnt, memTimeout);
        end
        dmemError = 1; hazard = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (stall !== 5'b00011 || nop !== 1'b1 || state !== 2'b01) begin
                errors++;
                $display("FAIL dmem_no_access cyc%0d: stall=%b nop=%b state=%b want 00011 1 01",
                         i, stall, nop, state);
            end
        end
        dmemError = 0; hazard = 0;
        cyc();
        checks++;
        if (bubbleCnt !== 3'd3 || freezeCnt !== 3'd3) begin
            errors++;
            $display("FAIL bubble_cnt: b=%0d f=%0d want 3 3", bubbleCnt, freezeCnt);
        end
    endtask

    task automatic test_flush_pend();
        clear_cnt();
        imemError = 1;
        cyc();
        branch = 1;
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_frozen: flush=%b want 0", flush);
        end
        cyc();
        branch = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (flush !== 1'b0 || state !== 2'b10) begin
                errors++;
                $display("FAIL flush_held cyc%0d: flush=%b state=%b want 0 10",
                         i, flush, state);
            end
        end
        imemError = 0;
        cyc();
        checks++;
        if (flush !== 1'b1 || state !== 2'b00) begin
            errors++;
            $display("FAIL flush_deliver: flush=%b state=%b want 1 00", flush, state);
        end
        cyc();
        checks++;
        if (flush !== 1'b0 || flushCnt !== 3'd1) begin
            errors++;
            $display("FAIL flush_once: flush=%b fcnt=%0d want 0 1", flush, flushCnt);
        end
        jump = 1;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL jump_flush: flush=%b want 1", flush);
        end
        jump = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        imemError = 1;
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (memTimeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: to=%b want 0", memTimeout);
        end
        cyc();
        checks++;
        if (memTimeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rise: to=%b want 1", memTimeout);
        end
        cyc();
        imemError = 0;
        cyc();
        checks++;
        if (memTimeout !== 1'b1 || state !== 2'b00 || freezeCnt !== 3'd6) begin
            errors++;
            $display("FAIL timeout_sticky: to=%b state=%b f=%0d want 1 00 6",
                     memTimeout, state, freezeCnt);
        end
        clear_cnt();
        checks++;
        if (memTimeout !== 1'b1 || freezeCnt !== 3'd0) begin
            errors++;
            $display("FAIL timeout_clrcnt: to=%b f=%0d want 1 0", memTimeout, freezeCnt);
        end
        do_reset();
        checks++;
        if (memTimeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rst: to=%b want 0", memTimeout);
        end
    endtask

    task automatic test_saturate_and_rst();
        clear_cnt();
        hazard = 1;
        for (int i = 0; i < 10; i++) cyc();
        hazard = 0;
        cyc();
        checks++;
        if (bubbleCnt !== 3'd7) begin
            errors++;
            $display("FAIL bubble_sat: b=%0d want 7", bubbleCnt);
        end
        clear_cnt();
        checks++;
        if (bubbleCnt !== 3'd0) begin
            errors++;
            $display("FAIL bubble_clr: b=%0d want 0", bubbleCnt);
        end
        imemError = 1;
        cyc();
        branch = 1;
        cyc();
        branch = 0;
        Rst = 1;
        #1;
        checks++;
        if (state !== 2'b00 || stall !== 5'b00000 || flush !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_freeze: state=%b stall=%b flush=%b want 00 00000 0",
                     state, stall, flush);
        end
        #1;
        Rst = 0;
        imemError = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (flush !== 1'b0 || flushCnt !== 3'd0) begin
                errors++;
                $display("FAIL rst_drop_pend cyc%0d: flush=%b fcnt=%0d want 0 0",
                         i, flush, flushCnt);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_bubble();
        test_priority();
        test_flush_pend();
        test_timeout();
        test_saturate_and_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
